// File: rtl/tl45_regfetch.sv
// tl45_regfetch: TL45 register-fetch stage. Holds the 16x32 register file and
// resolves forwarded operands into a registered buffer for the ALU stage.
`default_nettype none

module tl45_regfetch (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_stall,
  output logic        o_pipe_flush,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [3:0]  i_sr1,
  input  logic [3:0]  i_sr2,
  input  logic [31:0] i_imm,
  input  logic        i_imm_valid,
  input  logic [3:0]  i_jmp_cond,
  input  logic [31:0] i_pc,
  input  logic        i_decode_err,
  input  logic [3:0]  i_of1_reg,
  input  logic [31:0] i_of1_val,
  input  logic [3:0]  i_of2_reg,
  input  logic [31:0] i_of2_val,
  input  logic [3:0]  i_ld_pend_reg,
  input  logic [3:0]  i_wb_reg,
  input  logic [31:0] i_wb_val,
  output logic [4:0]  o_opcode,
  output logic [3:0]  o_dr,
  output logic [3:0]  o_jmp_cond,
  output logic [31:0] o_sr1_val,
  output logic [31:0] o_sr2_val,
  output logic [31:0] o_target_offset,
  output logic [31:0] o_pc,
  output logic        o_decode_err
);

  logic [31:0] regs [16];
  logic [31:0] sr1_res;
  logic [31:0] sr2_res;
  logic [31:0] sr2_sel;
  logic        hazard;

  // Youngest producer wins: ALU stage, then memory stage, then the write port.
  function automatic logic [31:0] resolve(
    input logic [3:0]  s,
    input logic [31:0] rf_val,
    input logic [3:0]  of1_reg,
    input logic [31:0] of1_val,
    input logic [3:0]  of2_reg,
    input logic [31:0] of2_val,
    input logic [3:0]  wb_reg,
    input logic [31:0] wb_val
  );
    if (s == 4'd0)
      return 32'd0;
    else if (s == of1_reg)
      return of1_val;
    else if (s == of2_reg)
      return of2_val;
    else if (s == wb_reg)
      return wb_val;
    else
      return rf_val;
  endfunction

  always_comb begin
    sr1_res = resolve(i_sr1, regs[i_sr1], i_of1_reg, i_of1_val,
                      i_of2_reg, i_of2_val, i_wb_reg, i_wb_val);
    sr2_res = resolve(i_sr2, regs[i_sr2], i_of1_reg, i_of1_val,
                      i_of2_reg, i_of2_val, i_wb_reg, i_wb_val);
    sr2_sel = i_imm_valid ? i_imm : sr2_res;
  end

  // An immediate second operand never reads sr2, so it cannot wait on a load.
  always_comb begin
    hazard = (i_opcode != 5'd0) && (i_ld_pend_reg != 4'd0) &&
             ((i_ld_pend_reg == i_sr1) ||
              ((i_ld_pend_reg == i_sr2) && !i_imm_valid));
  end

  assign o_pipe_stall = i_pipe_stall | hazard;
  assign o_pipe_flush = i_pipe_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= 32'd0;
    end else if (i_wb_reg != 4'd0) begin
      regs[i_wb_reg] <= i_wb_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_pipe_flush || (!i_pipe_stall && hazard)) begin
      o_opcode        <= 5'd0;
      o_dr            <= 4'd0;
      o_jmp_cond      <= 4'd0;
      o_sr1_val       <= 32'd0;
      o_sr2_val       <= 32'd0;
      o_target_offset <= 32'd0;
      o_pc            <= 32'd0;
      o_decode_err    <= 1'b0;
    end else if (!i_pipe_stall) begin
      o_opcode        <= i_opcode;
      o_dr            <= i_dr;
      o_jmp_cond      <= i_jmp_cond;
      o_sr1_val       <= sr1_res;
      o_sr2_val       <= sr2_sel;
      o_target_offset <= i_imm;
      o_pc            <= i_pc;
      o_decode_err    <= i_decode_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tl45_regfetch.sv
// tb_tl45_regfetch: scoreboard bench for tl45_regfetch with directed and random stimulus.
`default_nettype none

module tb_tl45_regfetch;

  logic        clk = 1'b0;
  logic        reset, pipe_stall, pipe_flush, imm_valid, decode_err;
  logic        o_stall, o_flush, o_derr;
  logic [4:0]  opcode, o_op;
  logic [3:0]  dr, sr1, sr2, jmp_cond, of1_reg, of2_reg, ld_pend, wb_reg;
  logic [3:0]  o_dr, o_jc;
  logic [31:0] imm, pc, of1_val, of2_val, wb_val;
  logic [31:0] o_s1, o_s2, o_off, o_pc;

  // next-cycle stimulus, applied at the falling edge by step()
  logic        n_reset, n_stall, n_flush, n_immv, n_derr;
  logic [4:0]  n_op;
  logic [3:0]  n_dr, n_sr1, n_sr2, n_jc, n_of1r, n_of2r, n_ld, n_wbr;
  logic [31:0] n_imm, n_pc, n_of1v, n_of2v, n_wbv;

  typedef struct {
    logic        stall, flush;
    logic [4:0]  op;
    logic [3:0]  dr, jc;
    logic [31:0] s1, s2, off, pc;
    logic        derr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mbuf;
  logic [31:0] mrf [16];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  tl45_regfetch dut (
    .i_clk(clk), .i_reset(reset), .i_pipe_stall(pipe_stall), .i_pipe_flush(pipe_flush),
    .o_pipe_stall(o_stall), .o_pipe_flush(o_flush),
    .i_opcode(opcode), .i_dr(dr), .i_sr1(sr1), .i_sr2(sr2), .i_imm(imm),
    .i_imm_valid(imm_valid), .i_jmp_cond(jmp_cond), .i_pc(pc), .i_decode_err(decode_err),
    .i_of1_reg(of1_reg), .i_of1_val(of1_val), .i_of2_reg(of2_reg), .i_of2_val(of2_val),
    .i_ld_pend_reg(ld_pend), .i_wb_reg(wb_reg), .i_wb_val(wb_val),
    .o_opcode(o_op), .o_dr(o_dr), .o_jmp_cond(o_jc), .o_sr1_val(o_s1), .o_sr2_val(o_s2),
    .o_target_offset(o_off), .o_pc(o_pc), .o_decode_err(o_derr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value as seen by an instruction reading register s this cycle.
  function automatic logic [31:0] operand(input logic [3:0] s);
    if (s == 0) return 0;
    if (s == n_of1r) return n_of1v;
    if (s == n_of2r) return n_of2v;
    if (n_wbr != 0 && s == n_wbr) return n_wbv;
    return mrf[s];
  endfunction

  task automatic clear_n();
    {n_reset, n_stall, n_flush, n_immv, n_derr} = '0;
    {n_op, n_dr, n_sr1, n_sr2, n_jc, n_of1r, n_of2r, n_ld, n_wbr} = '0;
    {n_imm, n_pc, n_of1v, n_of2v, n_wbv} = '0;
  endtask

  task automatic step();
    exp_t e;
    bit   haz, uses1, uses2;
    @(negedge clk);
    reset = n_reset; pipe_stall = n_stall; pipe_flush = n_flush;
    opcode = n_op; dr = n_dr; sr1 = n_sr1; sr2 = n_sr2; imm = n_imm; imm_valid = n_immv;
    jmp_cond = n_jc; pc = n_pc; decode_err = n_derr;
    of1_reg = n_of1r; of1_val = n_of1v; of2_reg = n_of2r; of2_val = n_of2v;
    ld_pend = n_ld; wb_reg = n_wbr; wb_val = n_wbv;
    uses1 = (n_sr1 == n_ld);
    uses2 = !n_immv && (n_sr2 == n_ld);
    haz   = (n_op != 0) && (n_ld != 0) && (uses1 || uses2);
    e = mbuf;
    e.stall = n_stall | haz;
    e.flush = n_flush;
    if (n_reset || n_flush || (!n_stall && haz)) begin
      e.op = 0; e.dr = 0; e.jc = 0; e.s1 = 0; e.s2 = 0; e.off = 0; e.pc = 0; e.derr = 0;
    end else if (!n_stall) begin
      e.op = n_op; e.dr = n_dr; e.jc = n_jc; e.pc = n_pc; e.derr = n_derr; e.off = n_imm;
      e.s1 = operand(n_sr1);
      e.s2 = n_immv ? n_imm : operand(n_sr2);
    end
    mbuf = e;
    if (n_reset) foreach (mrf[i]) mrf[i] = 0;
    else if (n_wbr != 0) mrf[n_wbr] = n_wbv;
    sb.push_back(e);
  endtask

  // Monitor: combinational outputs just after inputs settle, buffer just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) continue;
      e = sb[0];
      chk("o_pipe_stall", 32'(o_stall), 32'(e.stall));
      chk("o_pipe_flush", 32'(o_flush), 32'(e.flush));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("o_opcode", 32'(o_op), 32'(e.op));
      chk("o_dr", 32'(o_dr), 32'(e.dr));
      chk("o_jmp_cond", 32'(o_jc), 32'(e.jc));
      chk("o_sr1_val", o_s1, e.s1);
      chk("o_sr2_val", o_s2, e.s2);
      chk("o_target_offset", o_off, e.off);
      chk("o_pc", o_pc, e.pc);
      chk("o_decode_err", 32'(o_derr), 32'(e.derr));
    end
  end

  initial begin
    foreach (mrf[i]) mrf[i] = 0;
    mbuf = '{default: '0};
    clear_n();
    reset = 1; pipe_stall = 0; pipe_flush = 0; opcode = 0; dr = 0; sr1 = 0; sr2 = 0;
    imm = 0; imm_valid = 0; jmp_cond = 0; pc = 0; decode_err = 0; of1_reg = 0; of1_val = 0;
    of2_reg = 0; of2_val = 0; ld_pend = 0; wb_reg = 0; wb_val = 0;

    n_reset = 1; step(); step();
    clear_n();
    // writeback then read of r3
    n_wbr = 3; n_wbv = 32'h12345678; step();
    clear_n(); n_op = 1; n_sr1 = 3; n_sr2 = 0; step();
    // forwarding priority on r5
    n_wbr = 5; n_wbv = 32'hAA; n_of2r = 5; n_of2v = 32'hBB; n_of1r = 5; n_of1v = 32'hCC;
    n_sr1 = 5; step();
    n_of1r = 0; step();
    n_of2r = 0; step();
    // load-use hazard, then immediate avoids it
    clear_n(); n_ld = 4; n_op = 1; n_sr2 = 4; n_pc = 32'h100; step();
    n_immv = 1; n_imm = 32'h10; step();
    // hold across a 3-cycle stall while inputs change
    clear_n(); n_op = 1; n_dr = 2; n_pc = 32'h200; n_sr1 = 3; step();
    for (int i = 0; i < 3; i++) begin
      n_stall = 1; n_op = 5'(7 + i); n_dr = 4'(9 + i); n_of1r = 3; n_of1v = $urandom;
      n_pc = $urandom; n_ld = 3; step();
    end
    n_stall = 0; n_ld = 0; step();
    // flush beats stall
    clear_n(); n_op = 3; n_pc = 32'h300; n_derr = 1; step();
    n_flush = 1; n_stall = 1; step();
    // r0 is never written; r7 written during a flush
    clear_n(); n_wbr = 0; n_of1r = 0; n_wbv = 32'hFFFFFFFF; step();
    n_op = 1; n_sr1 = 0; step();
    clear_n(); n_flush = 1; n_wbr = 7; n_wbv = 32'hDEADBEEF; step();
    clear_n(); step();
    n_op = 2; n_sr1 = 7; n_sr2 = 7; step();
    // reset mid-stall
    n_stall = 1; n_reset = 1; step();
    clear_n(); n_op = 1; n_sr1 = 3; n_sr2 = 7; step();

    for (int c = 0; c < 400; c++) begin
      clear_n();
      n_reset = ($urandom_range(0, 99) == 0);
      n_flush = ($urandom_range(0, 19) == 0);
      n_stall = ($urandom_range(0, 5) == 0);
      n_op    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      n_dr = 4'($urandom); n_jc = 4'($urandom); n_derr = 1'($urandom);
      n_sr1 = 4'($urandom_range(0, 7)); n_sr2 = 4'($urandom_range(0, 7));
      n_imm = $urandom; n_immv = 1'($urandom); n_pc = $urandom;
      n_of1r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      n_of2r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      n_of1v = $urandom; n_of2v = $urandom;
      n_ld  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      n_wbr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 7)) : 4'd0;
      n_wbv = $urandom;
      step();
    end

    clear_n(); step();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tl45_regfetch.md
# tl45_regfetch

Register-fetch stage of the TL45 pipeline, between instruction decode and the ALU stage. It holds the 16×32 architectural register file and applies writeback to it. It resolves source operands with forwarding from the ALU and memory/writeback stages, detects load-use hazards and inserts bubbles. It presents a registered operand buffer that drives the ALU stage's operand, opcode, condition, offset and PC inputs.

## Interface
Parameters:
- none (register count 16, data width 32 fixed by ISA)

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_pipe_stall  in  1  stall from ALU stage; hold output buffer
- i_pipe_flush  in  1  flush from ALU stage; clear output buffer
- o_pipe_stall  out  1  stall to decode stage
- o_pipe_flush  out  1  flush to decode stage
- i_opcode  in  5  decoded opcode; 0 = NOP
- i_dr  in  4  destination register
- i_sr1, i_sr2  in  4 each  source register indices
- i_imm  in  32  immediate / branch offset
- i_imm_valid  in  1  1: sr2 operand is i_imm
- i_jmp_cond  in  4  branch condition code
- i_pc  in  32  instruction PC
- i_decode_err  in  1  decode error flag
- i_of1_reg, i_of1_val  in  4, 32  ALU-stage forward (reg 0 = none)
- i_of2_reg, i_of2_val  in  4, 32  memory-stage forward (reg 0 = none)
- i_ld_pend_reg  in  4  destination of an in-flight load whose data is not yet available (0 = none)
- i_wb_reg, i_wb_val  in  4, 32  register-file write port (reg 0 = no write)
- o_opcode, o_dr, o_jmp_cond  out  5, 4, 4  buffered fields
- o_sr1_val, o_sr2_val  out  32 each  resolved operands
- o_target_offset, o_pc  out  32 each  buffered immediate and PC
- o_decode_err  out  1  buffered decode error

## Operation
- Register file: r0 always reads 0, and writes to r0 are ignored. Other registers are written on the clock edge when i_wb_reg != 0, regardless of stall or flush. Reset clears all 16 registers.
- Operand resolution for a source index s, first match wins:
  - s == 0 → 0
  - s == i_of1_reg → i_of1_val
  - s == i_of2_reg → i_of2_val
  - s == i_wb_reg → i_wb_val (write-through)
  - otherwise → register file contents
- o_sr2_val = i_imm_valid ? i_imm : resolved(i_sr2).
- o_target_offset always carries i_imm.
- Hazard condition: i_opcode != 0, i_ld_pend_reg != 0, and i_ld_pend_reg matches i_sr1, or matches i_sr2 with i_imm_valid == 0.
- Combinational outputs:
  - o_pipe_stall = i_pipe_stall | hazard
  - o_pipe_flush = i_pipe_flush
- Output buffer update per clock edge, in priority order:
  1. i_reset or i_pipe_flush: all buffered outputs ← 0 (a NOP)
  2. i_pipe_stall: hold all buffered outputs
  3. hazard: buffered outputs ← 0 (bubble); decode stage is held by o_pipe_stall
  4. otherwise: capture opcode, dr, jmp_cond, resolved operands, imm, pc, decode_err
- i_decode_err is buffered unchanged. The ALU stage consumes it.

## Timing
- Latency: 1 cycle from decode inputs to buffered outputs.
- Reset values: every buffered output is 0. o_pipe_stall and o_pipe_flush follow their inputs combinationally, and hazard is 0 while i_opcode == 0.
- Writeback and capture in the same cycle: the captured operand equals i_wb_val through the bypass, not the stale register-file contents.
- Flush and stall asserted together: flush wins, buffer cleared.
- Hazard asserted while i_pipe_stall is high: buffer holds; no bubble is written.
- While the buffer is held, it is not refreshed by forwarding changes. The operands stay as captured.
- Reset mid-stall: buffer and register file are cleared on that edge.

## Test plan
- Reset, then write r3 ← 0x12345678 via wb. Next cycle decode sr1=3, sr2=0, opcode 1 → o_sr1_val=0x12345678, o_sr2_val=0.
- Same cycle i_wb_reg=5/0xAA, i_of2_reg=5/0xBB, i_of1_reg=5/0xCC, sr1=5 → o_sr1_val=0xCC. Drop of1 → 0xBB. Drop of2 → 0xAA.
- i_ld_pend_reg=4, opcode 1, sr2=4, i_imm_valid=0 → o_pipe_stall=1 and a zero bubble is buffered. Repeat with i_imm_valid=1 and i_imm=0x10 → no stall, o_sr2_val=0x10.
- Capture opcode 1, dr 2, then hold i_pipe_stall=1 for 3 cycles while inputs change → outputs unchanged. Release → new values captured.
- i_pipe_flush=1 with i_pipe_stall=1 → all outputs 0 and o_pipe_flush=1 the same cycle.
- Write r0 ← 0xFFFFFFFF, then read sr1=0 → o_sr1_val=0. Write r7 during a flush → r7 is updated on a later read.
